// File: rtl/food_placer.sv
// food_placer: samples random x/y candidates, rejects out-of-range or
// snake-occupied cells via a one-cycle lookup, and holds the accepted food
// cell until eaten. After MAX_TRIES rejections a raster scan takes over.
// Optional build macro: FOOD_BORDER_EXCL_EN (border cells never hold food).
module food_placer #(
  parameter int GRID_W    = 96,
  parameter int GRID_H    = 48,
  parameter int MAX_TRIES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] x_rand,
  input  logic [5:0] y_rand,
  input  logic       eaten,
  output logic [6:0] query_x,
  output logic [5:0] query_y,
  output logic       query_req,
  input  logic       query_hit,
  output logic [6:0] food_x,
  output logic [5:0] food_y,
  output logic       food_valid,
  output logic       food_new,
  output logic       scan_used
);

  localparam logic [1:0] SAMPLE = 2'd0;
  localparam logic [1:0] QUERY  = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] IDLE   = 2'd3;

`ifdef FOOD_BORDER_EXCL_EN
  localparam logic [6:0] X_LO = 7'd1;
  localparam logic [6:0] X_HI = 7'(GRID_W - 2);
  localparam logic [5:0] Y_LO = 6'd1;
  localparam logic [5:0] Y_HI = 6'(GRID_H - 2);
`else
  localparam logic [6:0] X_LO = 7'd0;
  localparam logic [6:0] X_HI = 7'(GRID_W - 1);
  localparam logic [5:0] Y_LO = 6'd0;
  localparam logic [5:0] Y_HI = 6'(GRID_H - 1);
`endif

  logic [1:0] state;
  logic [6:0] cand_x;
  logic [5:0] cand_y;
  logic [6:0] scan_x;
  logic [5:0] scan_y;
  logic [7:0] tries;
  logic       scan_mode;
  logic       in_range;
  logic       reject;

  // Candidate eligibility: inside the field, and off the border when excluded
  always_comb begin
    in_range = 1'b0;
`ifdef FOOD_BORDER_EXCL_EN
    in_range = (cand_x != 7'd0) && (cand_x < 7'(GRID_W - 1)) &&
               (cand_y != 6'd0) && (cand_y < 6'(GRID_H - 1));
`else
    in_range = (cand_x < 7'(GRID_W)) && (cand_y < 6'(GRID_H));
`endif
  end

  // A rejection is either an ineligible candidate or an occupied cell
  always_comb begin
    reject = ((state == QUERY) && !in_range) ||
             ((state == CHECK) && query_hit);
  end

  assign query_x   = cand_x;
  assign query_y   = cand_y;
  assign query_req = (state == QUERY) && in_range;

  // Placement FSM, rejection counter, scan counter and food registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SAMPLE;
      cand_x     <= '0;
      cand_y     <= '0;
      scan_x     <= X_LO;
      scan_y     <= Y_LO;
      tries      <= '0;
      scan_mode  <= 1'b0;
      scan_used  <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      food_new   <= 1'b0;
    end else begin
      food_new <= 1'b0;
      case (state)
        SAMPLE: begin
          if (scan_mode) begin
            cand_x <= scan_x;
            cand_y <= scan_y;
            if (scan_x == X_HI) begin
              scan_x <= X_LO;
              scan_y <= (scan_y == Y_HI) ? Y_LO : scan_y + 6'd1;
            end else begin
              scan_x <= scan_x + 7'd1;
            end
          end else begin
            cand_x <= x_rand;
            cand_y <= y_rand;
          end
          state <= QUERY;
        end
        QUERY: begin
          state <= in_range ? CHECK : SAMPLE;
        end
        CHECK: begin
          if (query_hit) begin
            state <= SAMPLE;
          end else begin
            food_x     <= cand_x;
            food_y     <= cand_y;
            food_valid <= 1'b1;
            food_new   <= 1'b1;
            tries      <= '0;
            scan_mode  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          if (eaten) begin
            food_valid <= 1'b0;
            state      <= SAMPLE;
          end
        end
      endcase
      // Counting stops once scan mode is entered; commit (mutually
      // exclusive with reject) clears both for the next placement.
      if (reject && !scan_mode) begin
        tries <= tries + 8'd1;
        if (tries + 8'd1 == 8'(MAX_TRIES)) begin
          scan_mode <= 1'b1;
          scan_used <= 1'b1;
        end
      end
    end
  end

endmodule
